// File: rtl/multi_debouncer.sv
// N-channel button debouncer. Each channel has its own synchroniser, a
// press/release qualification FSM driven by a shared sampling tick, and
// registered level / press-pulse / release-pulse outputs.
// Optional auto-repeat on held buttons: define MULTI_DEBOUNCER_AUTOREPEAT_EN.
module multi_debouncer #(
   parameter int unsigned N_CH          = 4,
   parameter int unsigned SYNC_STAGES   = 2,
   parameter int unsigned PRESS_TICKS   = 3,
   parameter int unsigned RELEASE_TICKS = 2,
   parameter int unsigned REPEAT_DELAY  = 8,
   parameter int unsigned REPEAT_PERIOD = 4
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            tick,
   input  logic [N_CH-1:0] button,
   output logic [N_CH-1:0] debounced,
   output logic [N_CH-1:0] press_p,
   output logic [N_CH-1:0] release_p
);

   localparam int unsigned CNT_MAX = (PRESS_TICKS > RELEASE_TICKS) ? PRESS_TICKS : RELEASE_TICKS;
   localparam int unsigned CW      = $clog2(CNT_MAX + 1);

   // The qualifying sample is the one arriving while cnt already holds TICKS-1.
   localparam logic [CW-1:0] PRESS_LAST   = CW'(PRESS_TICKS - 1);
   localparam logic [CW-1:0] RELEASE_LAST = CW'(RELEASE_TICKS - 1);
   localparam logic [CW-1:0] CNT_ONE      = CW'(1);

   typedef enum logic [1:0] {StIdle, StQualP, StPressed, StQualR} state_e;

   if (N_CH == 0 || SYNC_STAGES == 0 || PRESS_TICKS == 0 || RELEASE_TICKS == 0 ||
       REPEAT_DELAY == 0 || REPEAT_PERIOD == 0) begin : g_param_check
      $error("multi_debouncer: all parameters must be >= 1");
   end

   for (genvar i = 0; i < N_CH; i++) begin : g_ch
      logic [SYNC_STAGES-1:0] sync_q;
      logic                   s;
      state_e                 state_q, state_d;
      logic [CW-1:0]          cnt_q, cnt_d;
      logic                   deb_d, deb_q, press_q, rel_q;
      logic                   rep_fire;

      // Synchroniser shift chain for the asynchronous pad input
      always_ff @(posedge clk or negedge rst_n) begin
         if (!rst_n) begin
            sync_q <= '0;
         end else begin
            sync_q[0] <= button[i];
            for (int k = 1; k < SYNC_STAGES; k++) begin
               sync_q[k] <= sync_q[k-1];
            end
         end
      end

      assign s = sync_q[SYNC_STAGES-1];

      // Qualification FSM state and counter registers
      always_ff @(posedge clk or negedge rst_n) begin
         if (!rst_n) begin
            state_q <= StIdle;
            cnt_q   <= '0;
         end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
         end
      end

      // Next-state logic; a contradicting sample aborts on any clk, ticks only advance
      always_comb begin
         state_d = state_q;
         cnt_d   = cnt_q;
         unique case (state_q)
            StIdle: begin
               if (tick && s) begin
                  if (PRESS_TICKS == 1) begin
                     state_d = StPressed;
                  end else begin
                     state_d = StQualP;
                     cnt_d   = CNT_ONE;
                  end
               end
            end
            StQualP: begin
               if (!s) begin
                  state_d = StIdle;
                  cnt_d   = '0;
               end else if (tick) begin
                  if (cnt_q == PRESS_LAST) begin
                     state_d = StPressed;
                     cnt_d   = '0;
                  end else begin
                     cnt_d = cnt_q + CNT_ONE;
                  end
               end
            end
            StPressed: begin
               if (tick && !s) begin
                  if (RELEASE_TICKS == 1) begin
                     state_d = StIdle;
                  end else begin
                     state_d = StQualR;
                     cnt_d   = CNT_ONE;
                  end
               end
            end
            StQualR: begin
               if (s) begin
                  state_d = StPressed;
                  cnt_d   = '0;
               end else if (tick) begin
                  if (cnt_q == RELEASE_LAST) begin
                     state_d = StIdle;
                     cnt_d   = '0;
                  end else begin
                     cnt_d = cnt_q + CNT_ONE;
                  end
               end
            end
            default: begin
               state_d = StIdle;
               cnt_d   = '0;
            end
         endcase
      end

      assign deb_d = (state_d == StPressed) || (state_d == StQualR);

`ifdef MULTI_DEBOUNCER_AUTOREPEAT_EN
      localparam int unsigned REP_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY
                                                                       : REPEAT_PERIOD;
      localparam int unsigned RW = $clog2(REP_MAX + 1);
      localparam logic [RW-1:0] DELAY_LAST  = RW'(REPEAT_DELAY - 1);
      localparam logic [RW-1:0] PERIOD_LAST = RW'(REPEAT_PERIOD - 1);
      localparam logic [RW-1:0] REP_ONE     = RW'(1);

      logic [RW-1:0] rep_q, rep_d;
      logic          first_q, first_d;  // still waiting for the first (longer) delay

      // Repeat counter registers
      always_ff @(posedge clk or negedge rst_n) begin
         if (!rst_n) begin
            rep_q   <= '0;
            first_q <= 1'b1;
         end else begin
            rep_q   <= rep_d;
            first_q <= first_d;
         end
      end

      // Count ticks only while held in PRESSED; QUAL_R pauses, a fresh press restarts
      always_comb begin
         rep_d    = rep_q;
         first_d  = first_q;
         rep_fire = 1'b0;
         if (!deb_d || !deb_q) begin
            rep_d   = '0;
            first_d = 1'b1;
         end else if (tick && state_q == StPressed && state_d == StPressed) begin
            if (rep_q == (first_q ? DELAY_LAST : PERIOD_LAST)) begin
               rep_fire = 1'b1;
               rep_d    = '0;
               first_d  = 1'b0;
            end else begin
               rep_d = rep_q + REP_ONE;
            end
         end
      end
`else
      assign rep_fire = 1'b0;
`endif

      // Registered outputs; pulses coincide with the first cycle of the new level
      always_ff @(posedge clk or negedge rst_n) begin
         if (!rst_n) begin
            deb_q   <= 1'b0;
            press_q <= 1'b0;
            rel_q   <= 1'b0;
         end else begin
            deb_q   <= deb_d;
            press_q <= (deb_d & ~deb_q) | rep_fire;
            rel_q   <= ~deb_d & deb_q;
         end
      end

      assign debounced[i] = deb_q;
      assign press_p[i]   = press_q;
      assign release_p[i] = rel_q;
   end

endmodule

// File: tb/tb_multi_debouncer.sv
// Self-checking bench for multi_debouncer: table-driven vectors with tick tied
// high, plus hand-written multi-tick sequences with a tick every 4 clks.
module tb_multi_debouncer;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       tick;
   logic [3:0] button;
   logic [3:0] debounced, press_p, release_p;

   always #5 clk = ~clk;

   multi_debouncer #(
      .N_CH          (4),
      .SYNC_STAGES   (2),
      .PRESS_TICKS   (3),
      .RELEASE_TICKS (2),
      .REPEAT_DELAY  (8),
      .REPEAT_PERIOD (4)
   ) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .tick      (tick),
      .button    (button),
      .debounced (debounced),
      .press_p   (press_p),
      .release_p (release_p)
   );

   typedef struct {
      logic [3:0] b;
      logic [3:0] deb;
      logic [3:0] p;
      logic [3:0] r;
   } vec_t;

   vec_t vecs[25];

   int checks   = 0;
   int failures = 0;
   int tick_no;
   int press_cnt[4], rel_cnt[4], press_tick[4], rel_tick[4], low_tick[4];
   int rep_ticks[$];

   task automatic check(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         failures++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   task automatic clear_mon();
      tick_no = 0;
      for (int i = 0; i < 4; i++) begin
         press_cnt[i]  = 0;
         rel_cnt[i]    = 0;
         press_tick[i] = -1;
         rel_tick[i]   = -1;
         low_tick[i]   = -1;
      end
      rep_ticks.delete();
   endtask

   // One clk: drive tick at negedge, sample 1 time unit after posedge.
   task automatic cyc(input logic t);
      @(negedge clk);
      tick = t;
      @(posedge clk);
      #1;
      if (t) tick_no++;
      for (int i = 0; i < 4; i++) begin
         if (press_p[i] === 1'b1) begin
            press_cnt[i]++;
            press_tick[i] = tick_no;
            if (i == 0) rep_ticks.push_back(tick_no);
         end
         if (release_p[i] === 1'b1) begin
            rel_cnt[i]++;
            rel_tick[i] = tick_no;
         end
         if (debounced[i] !== 1'b1 && low_tick[i] < 0) low_tick[i] = tick_no;
      end
   endtask

   // n tick periods of 4 clks each, tick on the last clk.
   task automatic run_ticks(input int n);
      for (int k = 0; k < n; k++) begin
         cyc(1'b0);
         cyc(1'b0);
         cyc(1'b0);
         cyc(1'b1);
      end
   endtask

   task automatic setv(input int idx, input logic [3:0] b, input logic [3:0] deb,
                       input logic [3:0] p, input logic [3:0] r);
      vecs[idx].b   = b;
      vecs[idx].deb = deb;
      vecs[idx].p   = p;
      vecs[idx].r   = r;
   endtask

   initial begin
      // Tick tied high; each row: button driven, one clk, outputs expected after that edge.
      setv( 0, 4'b0000, 4'b0000, 4'b0000, 4'b0000);
      setv( 1, 4'b0100, 4'b0000, 4'b0000, 4'b0000);
      setv( 2, 4'b0101, 4'b0000, 4'b0000, 4'b0000);
      setv( 3, 4'b0111, 4'b0000, 4'b0000, 4'b0000);  // ch1 one-clk glitch
      setv( 4, 4'b0101, 4'b0000, 4'b0000, 4'b0000);
      setv( 5, 4'b0101, 4'b0100, 4'b0100, 4'b0000);
      setv( 6, 4'b0101, 4'b0101, 4'b0001, 4'b0000);
      setv( 7, 4'b0001, 4'b0101, 4'b0000, 4'b0000);
      setv( 8, 4'b0001, 4'b0101, 4'b0000, 4'b0000);
      setv( 9, 4'b0001, 4'b0101, 4'b0000, 4'b0000);
      setv(10, 4'b0001, 4'b0001, 4'b0000, 4'b0100);
      setv(11, 4'b0000, 4'b0001, 4'b0000, 4'b0000);  // ch0 low glitch during release
      setv(12, 4'b0001, 4'b0001, 4'b0000, 4'b0000);
      setv(13, 4'b0001, 4'b0001, 4'b0000, 4'b0000);
      setv(14, 4'b0001, 4'b0001, 4'b0000, 4'b0000);
      setv(15, 4'b1010, 4'b0001, 4'b0000, 4'b0000);
      setv(16, 4'b1010, 4'b0001, 4'b0000, 4'b0000);
      setv(17, 4'b1010, 4'b0001, 4'b0000, 4'b0000);
      setv(18, 4'b1010, 4'b0000, 4'b0000, 4'b0001);
      setv(19, 4'b1010, 4'b1010, 4'b1010, 4'b0000);
      setv(20, 4'b1010, 4'b1010, 4'b0000, 4'b0000);
      setv(21, 4'b0000, 4'b1010, 4'b0000, 4'b0000);
      setv(22, 4'b0000, 4'b1010, 4'b0000, 4'b0000);
      setv(23, 4'b0000, 4'b1010, 4'b0000, 4'b0000);
      setv(24, 4'b0000, 4'b0000, 4'b0000, 4'b1010);

      rst_n  = 1'b0;
      tick   = 1'b0;
      button = 4'hF;
      clear_mon();

      // 1. reset held with all buttons high, then released
      run_ticks(2);
      check("rst_debounced", int'(debounced), 0);
      check("rst_press", int'(press_p), 0);
      check("rst_release", int'(release_p), 0);
      check("rst_no_pulses", press_cnt[0] + press_cnt[1] + press_cnt[2] + press_cnt[3], 0);
      @(negedge clk);
      rst_n = 1'b1;
      clear_mon();
      run_ticks(5);
      for (int i = 0; i < 4; i++) begin
         check($sformatf("t1_press_cnt_ch%0d", i), press_cnt[i], 1);
         check($sformatf("t1_press_tick_ch%0d", i), press_tick[i], 3);
      end
      check("t1_debounced", int'(debounced), 15);

      // release everything
      clear_mon();
      button = 4'h0;
      run_ticks(4);
      for (int i = 0; i < 4; i++) begin
         check($sformatf("t1_rel_cnt_ch%0d", i), rel_cnt[i], 1);
         check($sformatf("t1_rel_tick_ch%0d", i), rel_tick[i], 2);
      end

      // 2. ch0: 2 high ticks, 1 low tick, 3 high ticks
      clear_mon();
      button = 4'b0001;
      run_ticks(2);
      button = 4'b0000;
      run_ticks(1);
      button = 4'b0001;
      run_ticks(3);
      check("t2_press_cnt_ch0", press_cnt[0], 1);
      check("t2_press_tick_ch0", press_tick[0], 6);
      check("t2_others_quiet", press_cnt[1] + press_cnt[2] + press_cnt[3], 0);

      // 3. ch1 release interrupted by a one-tick high glitch
      button = 4'b0011;
      run_ticks(4);
      check("t3_ch1_pressed", int'(debounced), 3);
      clear_mon();
      button = 4'b0001;
      run_ticks(1);
      button = 4'b0011;
      run_ticks(1);
      button = 4'b0001;
      run_ticks(2);
      check("t3_rel_cnt_ch1", rel_cnt[1], 1);
      check("t3_rel_tick_ch1", rel_tick[1], 4);
      check("t3_low_tick_ch1", low_tick[1], 4);
      check("t3_no_press_ch1", press_cnt[1], 0);
      check("t3_ch0_untouched", press_cnt[0] + rel_cnt[0], 0);

      // 4. tick tied high: press latency from a ch2 edge
      button = 4'b0000;
      run_ticks(3);
      cyc(1'b1);
      cyc(1'b1);
      cyc(1'b1);
      button = 4'b0100;
      for (int j = 1; j <= 8; j++) begin
         cyc(1'b1);
         check($sformatf("t4_press_clk%0d", j), int'(press_p), (j == 5) ? 4 : 0);
      end
      button = 4'b0000;
      for (int j = 0; j < 6; j++) cyc(1'b1);

      // table-driven vectors, tick tied high
      for (int j = 0; j < 25; j++) begin
         button = vecs[j].b;
         cyc(1'b1);
         check($sformatf("vec%0d_deb", j), int'(debounced), int'(vecs[j].deb));
         check($sformatf("vec%0d_press", j), int'(press_p), int'(vecs[j].p));
         check($sformatf("vec%0d_release", j), int'(release_p), int'(vecs[j].r));
      end
      cyc(1'b1);
      cyc(1'b1);

      // 5a. reset while ch3 is in QUAL_P
      clear_mon();
      button = 4'b1000;
      run_ticks(1);
      cyc(1'b0);
      #2 rst_n = 1'b0;
      #1;
      check("t5a_deb_in_reset", int'(debounced), 0);
      check("t5a_press_in_reset", int'(press_p), 0);
      button = 4'b0000;
      cyc(1'b0);
      cyc(1'b0);
      @(negedge clk);
      rst_n = 1'b1;
      run_ticks(4);
      check("t5a_no_press_ch3", press_cnt[3], 0);
      check("t5a_no_release_ch3", rel_cnt[3], 0);

      // 5b. reset while ch3 is in QUAL_R
      button = 4'b1000;
      run_ticks(4);
      check("t5b_pressed", int'(debounced), 8);
      button = 4'b0000;
      run_ticks(1);
      check("t5b_qual_r_level", int'(debounced), 8);
      #2 rst_n = 1'b0;
      #1;
      check("t5b_deb_in_reset", int'(debounced), 0);
      check("t5b_rel_in_reset", int'(release_p), 0);
      cyc(1'b0);
      cyc(1'b0);
      @(negedge clk);
      rst_n = 1'b1;
      clear_mon();
      run_ticks(4);
      check("t5b_no_release_ch3", rel_cnt[3], 0);
      check("t5b_no_press_ch3", press_cnt[3], 0);
      check("t5b_deb_after", int'(debounced), 0);

      // 6. long hold on ch0, then release
      clear_mon();
      button = 4'b0001;
      run_ticks(24);
      button = 4'b0000;
      run_ticks(3);
`ifdef MULTI_DEBOUNCER_AUTOREPEAT_EN
      begin
         int exp_rep[5];
         exp_rep = '{3, 11, 15, 19, 23};
         check("t6_rep_count", rep_ticks.size(), 5);
         for (int k = 0; k < 5; k++) begin
            check($sformatf("t6_rep%0d_tick", k),
                  (k < rep_ticks.size()) ? rep_ticks[k] : -1, exp_rep[k]);
         end
      end
`else
      check("t6_single_press", press_cnt[0], 1);
      check("t6_press_tick", press_tick[0], 3);
`endif
      check("t6_rel_cnt", rel_cnt[0], 1);
      check("t6_rel_tick", rel_tick[0], 26);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
